// File: rtl/tl_ul_ram_responder_if.sv
// TL-UL A/D channel bundle between a requester (master) and a responder (slave).
// Latency: none; wires only.
// Backpressure: a_ready throttles the A channel, d_ready throttles the D channel.
// Ports: A channel a_valid/a_ready/a_opcode/a_param/a_size/a_source/a_address/a_mask/a_data/a_corrupt,
//        D channel d_valid/d_ready/d_opcode/d_param/d_size/d_source/d_denied/d_data/d_corrupt.
interface tl_ul_ram_responder_if #(
   parameter int SRC_W = 3
);
   logic             a_valid;
   logic             a_ready;
   logic [2:0]       a_opcode;
   logic [2:0]       a_param;
   logic [1:0]       a_size;
   logic [SRC_W-1:0] a_source;
   logic [31:0]      a_address;
   logic [3:0]       a_mask;
   logic [31:0]      a_data;
   logic             a_corrupt;

   logic             d_valid;
   logic             d_ready;
   logic [2:0]       d_opcode;
   logic [1:0]       d_param;
   logic [1:0]       d_size;
   logic [SRC_W-1:0] d_source;
   logic             d_denied;
   logic [31:0]      d_data;
   logic             d_corrupt;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      input  a_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
      output d_ready
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      output a_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
      input  d_ready
   );
endinterface

// File: rtl/tl_ul_ram_responder.sv
// TL-UL responder: flop word RAM serving Get/PutFull/PutPartial, denying everything else.
// Latency: response visible the cycle after A-channel accept; writes visible to the next request.
// Backpressure: 2-entry response queue; a_ready drops only when it is full (registered, no input path).
// Ports: clock, reset (async, active-high), bus (tl_ul_ram_responder_if.slave: A channel in, D channel out).
module tl_ul_ram_responder #(
   parameter int          DEPTH = 16,
   parameter logic [31:0] BASE  = 32'h0000_0000,
   parameter int          SRC_W = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   tl_ul_ram_responder_if.slave  bus
);
   localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

   localparam logic [2:0] OP_PUT_FULL = 3'd0;
   localparam logic [2:0] OP_PUT_PART = 3'd1;
   localparam logic [2:0] OP_ARITH    = 3'd2;
   localparam logic [2:0] OP_LOGIC    = 3'd3;
   localparam logic [2:0] OP_GET      = 3'd4;

   typedef struct packed {
      logic [2:0]       opcode;
      logic [1:0]       size;
      logic [SRC_W-1:0] source;
      logic             denied;
      logic [31:0]      data;
   } rsp_t;

   logic [31:0] mem [DEPTH];
   rsp_t        q   [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   logic        accept;
   logic        drain;
   logic [31:0] offset;
   logic [IDX_W-1:0] idx;
   logic [1:0]  size_mask;
   logic        hit;
   logic        aligned;
   logic        op_ok;
   logic        legal;
   logic        do_write;
   rsp_t        new_rsp;
   rsp_t        head;

   // a_param carries no meaning for this responder.
   logic unused_param;
   assign unused_param = ^bus.a_param;

   // Both handshakes are functions of count only, so a_ready never sees d_ready or a_* combinationally.
   assign bus.a_ready = (count != 2'd2);
   assign bus.d_valid = (count != 2'd0);
   assign accept      = bus.a_valid && bus.a_ready;
   assign drain       = bus.d_valid && bus.d_ready;

   // Request decode. Subtracting BASE (rather than comparing bounds) also rejects addresses below BASE,
   // since they wrap to a large offset.
   always_comb begin
      size_mask = 2'b11;
      case (bus.a_size)
         2'd0:    size_mask = 2'b00;
         2'd1:    size_mask = 2'b01;
         default: size_mask = 2'b11;
      endcase
   end

   assign offset  = bus.a_address - BASE;
   assign idx     = offset[IDX_W+1:2];
   assign hit     = (offset < SPAN);
   assign aligned = ((bus.a_address[1:0] & size_mask) == 2'b00);
   assign op_ok   = (bus.a_opcode == OP_PUT_FULL) || (bus.a_opcode == OP_PUT_PART) ||
                    (bus.a_opcode == OP_GET);
   assign legal   = hit && aligned && (bus.a_size <= 2'd2) && op_ok &&
                    !((bus.a_opcode == OP_PUT_FULL) && bus.a_corrupt);
   // A poisoned PutPartial is acknowledged normally but must not touch the RAM.
   assign do_write = legal && !bus.a_corrupt &&
                     ((bus.a_opcode == OP_PUT_FULL) || (bus.a_opcode == OP_PUT_PART));

   always_comb begin
      new_rsp        = '0;
      new_rsp.opcode = ((bus.a_opcode == OP_GET) || (bus.a_opcode == OP_ARITH) ||
                        (bus.a_opcode == OP_LOGIC)) ? 3'd1 : 3'd0;
      new_rsp.size   = bus.a_size;
      new_rsp.source = bus.a_source;
      new_rsp.denied = !legal;
      // Read sees the RAM before this cycle's write lands.
      new_rsp.data   = (legal && (bus.a_opcode == OP_GET)) ? mem[idx] : 32'd0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < DEPTH; w++) begin
            mem[w] <= '0;
         end
      end else if (accept && do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.a_mask[b]) begin
               mem[idx][8*b +: 8] <= bus.a_data[8*b +: 8];
            end
         end
      end
   end

   // Two-entry response queue; one-bit pointers wrap naturally.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q[0]   <= '0;
         q[1]   <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (accept) begin
            q[wr_ptr] <= new_rsp;
            wr_ptr    <= ~wr_ptr;
         end
         if (drain) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({accept, drain})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head         = q[rd_ptr];
   assign bus.d_opcode = head.opcode;
   assign bus.d_param  = 2'd0;
   assign bus.d_size   = head.size;
   assign bus.d_source = head.source;
   assign bus.d_denied = head.denied;
   assign bus.d_data   = head.data;
   assign bus.d_corrupt = 1'b0;
endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Randomized + directed bench for tl_ul_ram_responder with a queue scoreboard and a word-array reference model.
// Latency: expected responses are queued at accept time and checked when the DUT presents them.
// Backpressure: d_ready is driven directly for directed cases and randomized in the random phase.
module tb_tl_ul_ram_responder;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          SRC_W = 3;

   typedef struct packed {
      logic [2:0]       opcode;
      logic [1:0]       size;
      logic [SRC_W-1:0] source;
      logic             denied;
      logic [31:0]      data;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   tl_ul_ram_responder_if #(.SRC_W(SRC_W)) bus ();

   tl_ul_ram_responder #(.DEPTH(DEPTH), .BASE(BASE), .SRC_W(SRC_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clock = ~clock;

   exp_t        sb[$];
   logic [31:0] ref_mem [DEPTH];
   int          compared   = 0;
   int          mismatched = 0;
   bit          auto_rdy   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int w = 0; w < DEPTH; w++) ref_mem[w] = 32'd0;
   endtask

   // Reference behaviour: decide legality from the address/size rules, then read or merge bytes.
   task automatic model(input logic [2:0] op, input logic [1:0] size, input logic [SRC_W-1:0] src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                        input logic corrupt);
      logic [31:0] off;
      bit          legal;
      int          w;
      exp_t        e;
      off   = addr - BASE;
      legal = (off < 32'(DEPTH * 4)) && ((addr % (32'd1 << size)) == 0) && (size <= 2'd2) &&
              (op == 3'd0 || op == 3'd1 || op == 3'd4) && !(op == 3'd0 && corrupt);
      w     = int'((off >> 2) % 32'(DEPTH));
      e.opcode = (op == 3'd4 || op == 3'd2 || op == 3'd3) ? 3'd1 : 3'd0;
      e.size   = size;
      e.source = src;
      e.denied = !legal;
      e.data   = (legal && op == 3'd4) ? ref_mem[w] : 32'd0;
      if (legal && (op == 3'd0 || op == 3'd1) && !corrupt) begin
         for (int b = 0; b < 4; b++) begin
            if (mask[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
         end
      end
      sb.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [SRC_W-1:0] src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                       input logic corrupt, output bit first_try);
      bus.a_valid   = 1'b1;
      bus.a_opcode  = op;
      bus.a_param   = 3'($urandom_range(0, 7));
      bus.a_size    = size;
      bus.a_source  = src;
      bus.a_address = addr;
      bus.a_mask    = mask;
      bus.a_data    = data;
      bus.a_corrupt = corrupt;
      first_try     = 1'b0;
      for (int t = 0; t < 64; t++) begin
         if (bus.a_ready) begin
            model(op, size, src, addr, mask, data, corrupt);
            first_try = (t == 0);
            @(posedge clock); #1;
            bus.a_valid = 1'b0;
            return;
         end
         @(posedge clock); #1;
      end
      bus.a_valid = 1'b0;
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: a_ready got 0 expected 1 within 64 cycles at %0t", $time);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 400; t++) begin
         if (sb.size() == 0) return;
         @(posedge clock); #1;
      end
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d responses outstanding expected 0", sb.size());
   endtask

   // Monitor: compares the head response every cycle it is valid (stall cycles check hold stability).
   initial begin
      logic [63:0] got;
      forever begin
         @(negedge clock);
         if (!reset && bus.d_valid) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_resp: d_valid got 1 expected 0 at %0t", $time);
            end else begin
               got = 64'({bus.d_opcode, bus.d_size, bus.d_source, bus.d_denied, bus.d_data});
               chk(bus.d_ready ? "resp" : "resp_hold", got, 64'(sb[0]));
               chk("d_param_corrupt", 64'({bus.d_param, bus.d_corrupt}), 64'd0);
               if (bus.d_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clock); #1;
         if (auto_rdy) bus.d_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      bit          ft;
      logic [2:0]  op;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdat;

      bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0;
      bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0;
      bus.a_corrupt = 1'b0; bus.d_ready = 1'b0;
      clear_model();

      repeat (3) @(posedge clock);
      #1;
      chk("rst_a_ready", 64'(bus.a_ready), 64'd1);
      chk("rst_d_valid", 64'(bus.d_valid), 64'd0);
      chk("rst_d_fields", 64'({bus.d_opcode, bus.d_size, bus.d_source, bus.d_denied, bus.d_data}), 64'd0);
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      bus.d_ready = 1'b1;

      // Full write, read back, partial merge, denials, atomic.
      send(3'd0, 2'd2, 3'd2, BASE + 32'd4, 4'hF, 32'hDEAD_BEEF, 1'b0, ft);
      chk("put_dvalid_next", 64'(bus.d_valid), 64'd1);
      send(3'd4, 2'd2, 3'd3, BASE + 32'd4, 4'h0, 32'd0, 1'b0, ft);
      send(3'd1, 2'd2, 3'd1, BASE + 32'd4, 4'b0010, 32'h0000_5500, 1'b0, ft);
      send(3'd4, 2'd2, 3'd0, BASE + 32'd4, 4'h0, 32'd0, 1'b0, ft);
      send(3'd4, 2'd2, 3'd4, BASE + 32'(DEPTH * 4), 4'h0, 32'd0, 1'b0, ft);
      send(3'd4, 2'd2, 3'd5, BASE + 32'd2, 4'h0, 32'd0, 1'b0, ft);
      send(3'd2, 2'd2, 3'd5, BASE + 32'd4, 4'hF, 32'h1111_1111, 1'b0, ft);
      send(3'd1, 2'd2, 3'd6, BASE + 32'd4, 4'hF, 32'h2222_2222, 1'b1, ft);
      send(3'd4, 2'd2, 3'd7, BASE + 32'd4, 4'h0, 32'd0, 1'b0, ft);
      wait_drain();

      // Backpressure: queue fills at two, third waits until a drain.
      bus.d_ready = 1'b0;
      send(3'd4, 2'd2, 3'd0, BASE + 32'd4, 4'h0, 32'd0, 1'b0, ft);
      send(3'd4, 2'd2, 3'd1, BASE + 32'd8, 4'h0, 32'd0, 1'b0, ft);
      fork
         send(3'd4, 2'd2, 3'd2, BASE + 32'd4, 4'h0, 32'd0, 1'b0, ft);
         begin
            chk("a_ready_full", 64'(bus.a_ready), 64'd0);
            repeat (2) begin @(posedge clock); #1; end
            chk("a_ready_stall", 64'(bus.a_ready), 64'd0);
            bus.d_ready = 1'b1;
            @(posedge clock); #1;
            chk("a_ready_after_drain", 64'(bus.a_ready), 64'd1);
         end
      join
      wait_drain();

      // Back-to-back Put then Get to the same word.
      wdat = $urandom;
      send(3'd0, 2'd2, 3'd3, BASE + 32'd8, 4'hF, wdat, 1'b0, ft);
      chk("b2b_put_first_try", 64'(ft), 64'd1);
      chk("b2b_dvalid_1", 64'(bus.d_valid), 64'd1);
      send(3'd4, 2'd2, 3'd4, BASE + 32'd8, 4'h0, 32'd0, 1'b0, ft);
      chk("b2b_get_first_try", 64'(ft), 64'd1);
      chk("b2b_dvalid_2", 64'(bus.d_valid), 64'd1);
      wait_drain();

      // Random traffic with random D-channel backpressure.
      auto_rdy = 1'b1;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 9: op = 3'd4;
            4, 5:          op = 3'd0;
            6, 7:          op = 3'd1;
            default: begin
               op = 3'($urandom_range(2, 7));
               if (op == 3'd4) op = 3'd5;
            end
         endcase
         size = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
         addr = BASE + 32'($urandom_range(0, DEPTH * 4 + 7));
         if ($urandom_range(0, 3) != 0) addr = addr & ~32'd3;
         if ($urandom_range(0, 9) == 0) addr = $urandom;
         send(op, size, 3'($urandom), addr, 4'($urandom), $urandom,
              ($urandom_range(0, 7) == 0), ft);
         if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
      end
      auto_rdy = 1'b0;
      @(posedge clock); #2;
      bus.d_ready = 1'b1;
      @(posedge clock); #1;
      wait_drain();

      // Reset with a full queue discards responses and clears the RAM.
      bus.d_ready = 1'b0;
      send(3'd0, 2'd2, 3'd1, BASE + 32'd12, 4'hF, 32'h1234_5678, 1'b0, ft);
      send(3'd4, 2'd2, 3'd2, BASE + 32'd12, 4'h0, 32'd0, 1'b0, ft);
      chk("full_before_reset", 64'(bus.a_ready), 64'd0);
      #2 reset = 1'b1;
      #1;
      chk("reset_d_valid", 64'(bus.d_valid), 64'd0);
      chk("reset_a_ready", 64'(bus.a_ready), 64'd1);
      sb.delete();
      clear_model();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      bus.d_ready = 1'b1;
      send(3'd4, 2'd2, 3'd4, BASE + 32'd12, 4'h0, 32'd0, 1'b0, ft);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
